// File: rtl/seg_scan_display.sv
// Converts count_50 to BCD with a serial double-dabble FSM and scans four
// common-anode digits: [3] range error, [2] count_10, [1] tens, [0] ones.
module seg_scan_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_10,
  input  logic [5:0] count_50,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_snap_50;
  logic [3:0]       r_snap_10;
  logic [13:0]      r_sr;
  logic [2:0]       r_shcnt;
  logic [3:0]       r_disp_ones, r_disp_tens, r_disp_10;
  logic             r_busy;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_change, w_capture, w_shift, w_commit;
  logic [13:0]      w_sr_adj;
  logic             w_wrap, w_err;
  logic [1:0]       w_idx_next;
  logic [6:0]       w_seg_al;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  assign w_change = {count_50, count_10} != {r_snap_50, r_snap_10};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_change) w_next = S_SHIFT;
      S_SHIFT: if (r_shcnt == 3'd5) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == S_IDLE) && w_change;
    w_shift   = (r_state == S_SHIFT);
    w_commit  = (r_state == S_DONE);
  end

  assign w_sr_adj = {dd_adj(r_sr[13:10]), dd_adj(r_sr[9:6]), r_sr[5:0]};

  // Busy spans the capture edge through the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_50   <= '0;
      r_snap_10   <= '0;
      r_sr        <= '0;
      r_shcnt     <= '0;
      r_disp_ones <= '0;
      r_disp_tens <= '0;
      r_disp_10   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= w_capture || (r_state != S_IDLE);
      if (w_capture) begin
        r_snap_50 <= count_50;
        r_snap_10 <= count_10;
        r_sr      <= {8'd0, count_50};
        r_shcnt   <= '0;
      end
      if (w_shift) begin
        r_sr    <= w_sr_adj << 1;
        r_shcnt <= r_shcnt + 3'd1;
      end
      if (w_commit) begin
        r_disp_ones <= r_sr[9:6];
        r_disp_tens <= r_sr[13:10];
        r_disp_10   <= r_snap_10;
      end
    end
  end

  assign w_wrap     = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_err      = (r_snap_50 > 6'd49) || (r_snap_10 > 4'd9);

  always_comb begin
    w_seg_al = SEG_BLANK;
    case (w_idx_next)
      2'd0: w_seg_al = glyph(r_disp_ones);
      2'd1: w_seg_al = (r_disp_tens == 4'd0) ? SEG_BLANK : glyph(r_disp_tens);
      2'd2: w_seg_al = glyph(r_disp_10);
      2'd3: w_seg_al = w_err ? SEG_E : SEG_BLANK;
      default: w_seg_al = SEG_BLANK;
    endcase
  end

  // an and seg are loaded from the same next index so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= 4'b1110;
      r_seg <= SEG_ACTIVE_LOW ? SEG_ZERO : ~SEG_ZERO;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      r_idx <= w_idx_next;
      r_an  <= ~(4'b0001 << w_idx_next);
      r_seg <= SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = SEG_ACTIVE_LOW;
  assign conv_busy = r_busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with SCAN_DIV=4: checks reset, conversion timing
// and the scanned digit pattern against a decimal-arithmetic reference.
module tb_seg_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_10;
  logic [5:0] count_50;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;

  int n_vec;
  int n_err;

  logic [3:0] s_an[16];
  logic [6:0] s_seg[16];

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GE    = 7'b0000110;

  seg_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .count_10(count_10), .count_50(count_50),
    .seg(seg), .dp(dp), .an(an), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b1000000;
      1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;
      3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;
      5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;
      7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;
      9: glyph = 7'b0010000;
      default: glyph = BLANK;
    endcase
  endfunction

  // Reference: what digit d shows for inputs (v50, v10) once settled.
  function automatic logic [6:0] ref_seg(input int d, input int v50, input int v10);
    case (d)
      0: ref_seg = glyph(v50 % 10);
      1: ref_seg = (v50 / 10 == 0) ? BLANK : glyph(v50 / 10);
      2: ref_seg = glyph(v10);
      default: ref_seg = (v50 > 49 || v10 > 9) ? GE : BLANK;
    endcase
  endfunction

  task automatic apply(input int v50, input int v10);
    @(negedge clk);
    count_50 = v50[5:0];
    count_10 = v10[3:0];
    repeat (12) @(negedge clk);
  endtask

  // Aligns to the first cycle of digit 0 and records one full scan.
  task automatic grab_scan(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = an;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) ok = 1'b1;
      else prev = an;
    end
    if (ok) begin
      s_an[0] = an;
      s_seg[0] = seg;
      for (int i = 1; i < 16; i++) begin
        @(negedge clk);
        s_an[i] = an;
        s_seg[i] = seg;
      end
    end
  endtask

  task automatic test_reset;
    int cnt;
    @(negedge clk);
    rst = 1'b1; count_50 = 6'd37; count_10 = 4'd4;
    repeat (2) @(negedge clk);
    n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL reset_an: got %b expected 1110", an); end
    n_vec++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
    n_vec++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b expected 1", dp); end
    n_vec++; if (conv_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", conv_busy); end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (conv_busy === 1'b1) cnt++;
    end
    n_vec++; if (cnt != 8) begin n_err++; $display("FAIL startup_busy_cycles: got %0d expected 8", cnt); end
  endtask

  task automatic test_normal;
    bit ok;
    grab_scan(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL normal_align: got timeout expected an=1110 start"); end
    else for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (s_an[i] !== ~(4'b0001 << (i / 4)) || s_seg[i] !== ref_seg(i / 4, 37, 4)) begin
        n_err++;
        $display("FAIL normal_scan c%0d: got an=%b seg=%b expected an=%b seg=%b", i, s_an[i], s_seg[i],
                 ~(4'b0001 << (i / 4)), ref_seg(i / 4, 37, 4));
      end
    end
  endtask

  task automatic scan_case(input string name, input int v50, input int v10);
    bit ok;
    apply(v50, v10);
    grab_scan(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL %s_align: got timeout expected an=1110 start", name); end
    else for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (s_an[d*4] !== ~(4'b0001 << d) || s_seg[d*4+2] !== ref_seg(d, v50, v10)) begin
        n_err++;
        $display("FAIL %s d%0d (%0d/%0d): got an=%b seg=%b expected an=%b seg=%b", name, d, v50, v10,
                 s_an[d*4], s_seg[d*4+2], ~(4'b0001 << d), ref_seg(d, v50, v10));
      end
    end
  endtask

  task automatic test_leading_zero;
    scan_case("lead_zero", 5, int'($urandom_range(0, 9)));
    scan_case("maxima", 49, 9);
  endtask

  task automatic test_out_of_range;
    scan_case("oor_50", 55, 3);
    scan_case("oor_10", 20, 12);
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++)
      scan_case("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
  endtask

  // Starts from reset so the scan phase is known: digit 0 is lit after E15.
  task automatic test_mid_conv;
    @(negedge clk);
    rst = 1'b1; count_50 = 6'd12; count_10 = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) count_50 = 6'd13;
      if (k == 7) begin
        n_vec++; if (conv_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_e7: got %b expected 1", conv_busy); end
      end
      if (k == 15) begin
        n_vec++; if (an !== 4'b1110 || seg !== glyph(2)) begin
          n_err++; $display("FAIL mid_old_value: got an=%b seg=%b expected an=1110 seg=%b", an, seg, glyph(2));
        end
        n_vec++; if (conv_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_e15: got %b expected 1", conv_busy); end
      end
      if (k == 16) begin
        n_vec++; if (seg !== glyph(3)) begin n_err++; $display("FAIL mid_new_value: got %b expected %b", seg, glyph(3)); end
        n_vec++; if (conv_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_e16: got %b expected 0", conv_busy); end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    count_50 = 6'd37; count_10 = 4'd4;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (conv_busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      n_err++; $display("FAIL rstmid_abort: got busy=%b an=%b seg=%b expected busy=0 an=1110 seg=1000000", conv_busy, an, seg);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (conv_busy !== 1'b1 || seg !== 7'b1000000) begin
      n_err++; $display("FAIL rstmid_restart: got busy=%b seg=%b expected busy=1 seg=1000000", conv_busy, seg);
    end
    repeat (3) @(negedge clk);
    n_vec++; if (an !== 4'b1101 || seg !== BLANK) begin
      n_err++; $display("FAIL rstmid_tens_blank: got an=%b seg=%b expected an=1101 seg=1111111", an, seg);
    end
    repeat (12) @(negedge clk);
    grab_scan(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_align: got timeout expected an=1110 start"); end
    else for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (s_seg[d*4+1] !== ref_seg(d, 37, 4)) begin
        n_err++; $display("FAIL rstmid_final d%0d: got %b expected %b", d, s_seg[d*4+1], ref_seg(d, 37, 4));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    count_50 = '0;
    count_10 = '0;
    test_reset;
    test_normal;
    test_leading_zero;
    test_out_of_range;
    test_random;
    test_mid_conv;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Downstream consumer of the cascaded divide-by-50 / divide-by-10 counter stage. Takes the live count_50 (0..49) and count_10 (0..9) values and converts count_50 to two BCD digits with an iterative double-dabble FSM. Drives a 4-digit multiplexed common-anode 7-segment display. Runs entirely on the system clock; scan timing comes from an internal prescaler, not from the divided clocks.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (1 kHz/digit at 50 MHz); legal range >= 2
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low-active; 0 = all seg/dp bits inverted (an unaffected)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
count_10  input  4  units value from counter stage, valid 0..9
count_50  input  6  value from counter stage, valid 0..49
seg  output  7  segments {g,f,e,d,c,b,a}
dp  output  1  decimal point, always off
an  output  4  digit anodes, active-low one-hot; an[0] = rightmost digit
conv_busy  output  1  high while conversion FSM is not IDLE

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset:
  - FSM enters IDLE. snap_50, snap_10, disp_ones, disp_tens and disp_10 clear to 0.
  - Prescaler and digit index idx clear to 0.
  - Outputs after reset: an=1110, seg=1000000 ('0'), dp=1, conv_busy=0.
  - Reset mid-conversion aborts the conversion. No partial result is written.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: on any edge where {count_50,count_10} != {snap_50,snap_10}, capture both inputs into snap. Load the shift register {tens[3:0],ones[3:0],bin[5:0]} = {0,0,count_50}. Clear shift counter and go to SHIFT (edge E0).
  - SHIFT: each edge, add 3 to each BCD nibble that is >= 5, then shift left by 1. After 6 shifts (E1..E6) go to DONE.
  - DONE (E7): write disp_ones, disp_tens and disp_10 = snap_10 atomically, then go to IDLE.
  - Latency: new digits are held in display registers after E7, i.e. 7 edges after capture.
  - Inputs are ignored outside IDLE. A value change during conversion is picked up at the first IDLE edge after DONE.
  - conv_busy = (state != IDLE), registered.
- Digit mapping, all taken from display registers:
  - digit0 = disp_ones.
  - digit1 = disp_tens, blank when disp_tens == 0 (leading-zero suppression).
  - digit2 = disp_10.
  - digit3 = 'E' when snap_50 > 49 or snap_10 > 9, else blank. Out-of-range values are still converted and shown (count_50 up to 63 gives tens up to 6).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge idx increments mod 4 (3 -> 0).
  - an and seg are registered and change on the same edge, so there is no ghosting skew between them.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, blank=1111111
  - BCD codes 10..15 display blank.

Test Plan:
- Reset and startup: hold rst 2 cycles with count_50=37 -> an=1110, seg=1000000, conv_busy=0. After release, conv_busy=1 for exactly 8 cycles (E0..E7).
- Normal value, SCAN_DIV=4, count_50=37, count_10=4: after conversion, an cycles 1110,1101,1011,0111, 4 clk each. seg per digit is 1111000 ('7'), 0110000 ('3'), 0011001 ('4'), 1111111 (blank).
- Leading zero and maxima:
  - count_50=5 -> digit1 seg=1111111, digit0=0010010.
  - count_50=49, count_10=9 -> digits 9,4,9, digit3 blank.
- Out of range: count_50=55 -> digit0 and digit1 both 0010010, digit3=0000110. Then count_10=12 with count_50=20 -> digit3=0000110 and digit2 blank.
- Mid-conversion change: change count_50 from 12 to 13 at E3 -> display shows 12 after E7. Capture of 13 occurs at E8, and 13 is displayed after E15.
- Reset mid-conversion: assert rst at E4 -> next cycle conv_busy=0, all display digits 0 (digit1 blank), an=1110. Conversion of the held inputs restarts on the first edge after release.
